mm_result_serializer: RTL and testbench
=======================================

Name: mm_result_serializer

Overview:
- Output-side companion to the pipelined 256-bit modular multiplier: captures every result presented on the multiplier's out_valid/Q pair.
- The multiplier cannot be stalled, so results are buffered in a small FIFO.
- Each buffered result is streamed out as eight 32-bit words over a valid/ready interface, most-significant word first, with a last-word marker and a wrapping result sequence number.
- Sits between the multiplier output and the host/bus-side consumer.

Parameters:
- DATA_W, 256, width of one multiplier result; must equal WORD_W*NWORDS.
- WORD_W, 32, output word width.
- DEPTH, 4, FIFO depth in results; power of 2, at least 2.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- res_valid  in  1  connects to the multiplier out_valid; one-cycle pulse per result.
- res_data  in  DATA_W  connects to the multiplier Q; sampled only when res_valid=1.
- out_valid  out  1  an output word is presented.
- out_ready  in  1  consumer accepts a word.
- out_data  out  WORD_W  current output word.
- out_last  out  1  high on the final (least-significant) word of a result.
- out_seq  out  8  sequence number of the result being sent.
- level  out  $clog2(DEPTH)+1  number of results stored, including the one in transmission.
- overflow  out  1  sticky; set when a result is dropped.
- drop_cnt  out  8  saturating count of dropped results.
- clr_ovf  in  1  clears overflow and drop_cnt.

Behaviour:
- **Reset** (reset=0 at a rising edge):
  - FIFO is emptied, rd/wr pointers are zeroed, word index = 0, and the FSM goes to IDLE.
  - Outputs: out_valid=0, out_data=0, out_last=0, out_seq=0, level=0, overflow=0, drop_cnt=0.
  - A reset in mid-transmission abandons the current result; the next result after reset carries seq 0.
- **Accept**:
  - When res_valid=1 and the FIFO is not full, res_data is written at wr_ptr and level increments.
  - The write is tagged with the next write sequence number; that counter increments by 1 and wraps 255->0.
- **Full**:
  - Full is level==DEPTH, unless the current cycle completes a pop (final-word handshake). A pop therefore frees the slot in the same cycle, and a simultaneous write is accepted.
  - When res_valid=1 while full:
    - The result is discarded.
    - overflow is set and drop_cnt increments, saturating at 255.
    - The write sequence counter still increments, so gaps in out_seq expose the loss.
- **Read FSM**:
  - IDLE: if level>0, load the entry at rd_ptr into the shift register, set out_valid=1 next cycle, and go to SEND.
  - SEND:
    - out_data = bits [DATA_W-1-32*idx -: 32], with idx = 0..7.
    - A handshake is out_valid & out_ready; on each handshake, idx increments.
    - On the handshake at idx=7 (out_last=1): rd_ptr increments and level decrements.
      - If another entry remains, load it and stay in SEND with no bubble, keeping out_valid=1.
      - Otherwise go to IDLE and deassert out_valid.
- **Stability**:
  - While out_valid=1 and out_ready=0, out_data, out_last and out_seq hold.
  - out_valid never drops without a handshake, except on reset.
- **Latency**: a result captured at edge N (FIFO previously empty and IDLE) gives its first word with out_valid=1 after edge N+1.
- **Throughput**: 1 word/cycle with out_ready held high, i.e. 8 cycles per result. Sustained input faster than 1 result per 8 cycles fills the FIFO.
- **Simultaneous write and read** in a non-full FIFO: level is unchanged.
- **clr_ovf**: clears overflow and drop_cnt. If clr_ovf and a drop coincide, the drop wins: overflow=1 and drop_cnt=1.
- All outputs are registered; there is no combinational path from res_* to out_*.

Test Plan:
- Single result 7aa790fb62f949ed3b4f3fce2d1b3c63c9f429ebabbbc258df59d4a4076784e0 with out_ready=1 -> out_valid rises one cycle after capture.
  - Words, in order: 7aa790fb, 62f949ed, 3b4f3fce, 2d1b3c63, c9f429eb, abbbc258, df59d4a4, 076784e0.
  - out_last only on the 8th word; out_seq=0; level 1->0.
- Two back-to-back results (second 09a752f6...40007ff1) with out_ready=1 -> 16 contiguous words with no bubble; second result has out_seq=1 and first word 09a752f6.
- Backpressure: toggle out_ready 1,0,0,1,... -> each word held stable while stalled, no word lost or duplicated, 8 handshakes per result.
- Overflow: out_ready=0, DEPTH+2=6 res_valid pulses -> level=4, overflow=1, drop_cnt=2.
  - Then out_ready=1: out_seq sequence is 0,1,2,3, then the next accepted result has seq 6.
  - Pulsing clr_ovf then gives overflow=0, drop_cnt=0.
- Full with simultaneous pop: FIFO full, res_valid coincides with the final-word handshake -> new result accepted, level stays 4, overflow stays 0.
- Reset mid-transmission: reset=0 after the 3rd word -> next cycle out_valid=0, level=0. After release, a new result streams from its first word with out_seq=0.

Source files
------------

// File: rtl/mm_result_serializer.sv
// ---------------------------------------------------------------------------
// mm_result_serializer
//
// Output-side companion to the pipelined 256-bit modular multiplier. Every
// result presented on res_valid/res_data is captured into a small FIFO,
// because the multiplier cannot be stalled. Each buffered result is then
// streamed out most-significant word first over a valid/ready interface.
// Each word carries a last-word marker and the result's wrapping sequence
// number.
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-low reset
//   res_valid  in   one-cycle pulse per multiplier result
//   res_data   in   multiplier result, sampled when res_valid=1
//   out_valid  out  an output word is presented
//   out_ready  in   consumer accepts the presented word
//   out_data   out  current output word
//   out_last   out  final (least-significant) word of a result
//   out_seq    out  sequence number of the result being sent
//   level      out  results stored, including the one being sent
//   overflow   out  sticky flag, set when a result is dropped
//   drop_cnt   out  saturating count of dropped results
//   clr_ovf    in   clears overflow and drop_cnt
// ---------------------------------------------------------------------------
module mm_result_serializer #(
  parameter int DATA_W = 256,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_last,
  output logic [7:0]                 out_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);

  localparam int NWORDS = DATA_W / WORD_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO = LW'(0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);
  localparam logic [IW-1:0] IDX_PREV = IW'(NWORDS - 2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Storage
  logic [DATA_W-1:0] r_mem     [DEPTH];
  logic [7:0]        r_seq_mem [DEPTH];

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [7:0]        r_wseq;

  // Read side
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_idx;
  logic              r_valid;
  logic              r_last;
  logic [7:0]        r_seq;

  // Error tracking
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  logic              w_hs;
  logic              w_pop;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_load;
  logic [PW-1:0]     w_rd_sel;

  // A pop frees its slot in the same cycle, so a coincident write is accepted.
  assign w_hs   = r_valid & out_ready;
  assign w_pop  = w_hs & (r_idx == IDX_LAST);
  assign w_full = (r_level == LVL_FULL) & ~w_pop;
  assign w_push = res_valid & ~w_full;
  assign w_drop = res_valid & w_full;

  // A new entry is loaded from IDLE, or right after a pop when another entry
  // remains; in the latter case the next entry sits one slot past rd_ptr.
  assign w_load   = ((r_state == ST_IDLE) & (r_level != LVL_ZERO)) |
                    (w_pop & (r_level > LVL_ONE));
  assign w_rd_sel = (r_state == ST_IDLE) ? r_rd_ptr : (r_rd_ptr + PW'(1));

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_level != LVL_ZERO) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (w_pop && (r_level == LVL_ONE)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO write side, pointers, level and write sequence counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_wseq   <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]     <= res_data;
        r_seq_mem[r_wr_ptr] <= r_wseq;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      // Dropped results still consume a sequence number so gaps are visible.
      if (res_valid) begin
        r_wseq <= r_wseq + 8'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Output shift register, word index, valid/last/seq
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_seq   <= 8'd0;
    end else begin
      if (w_load) begin
        r_shift <= r_mem[w_rd_sel];
        r_seq   <= r_seq_mem[w_rd_sel];
        r_idx   <= '0;
        r_valid <= 1'b1;
        r_last  <= (NWORDS == 1);
      end else if (w_pop) begin
        r_shift <= r_shift << WORD_W;
        r_idx   <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_hs) begin
        r_shift <= r_shift << WORD_W;
        r_idx   <= r_idx + IW'(1);
        r_last  <= (r_idx == IDX_PREV);
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_shift[DATA_W-1 -: WORD_W];
  assign out_last  = r_last;
  assign out_seq   = r_seq;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mm_result_serializer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for mm_result_serializer.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mm_result_serializer;

  logic         clock = 1'b0;
  logic         reset;
  logic         res_valid;
  logic [255:0] res_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [7:0]   out_seq;
  logic [2:0]   level;
  logic         overflow;
  logic [7:0]   drop_cnt;
  logic         clr_ovf;

  int n_cmp = 0;
  int n_err = 0;
  int bp_phase = 0;

  localparam logic [255:0] R1 =
    256'h7aa790fb62f949ed3b4f3fce2d1b3c63c9f429ebabbbc258df59d4a4076784e0;
  localparam logic [255:0] R2 =
    256'h09a752f6_11111111_22222222_33333333_44444444_55555555_66666666_40007ff1;

  mm_result_serializer #(.DATA_W(256), .WORD_W(32), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .res_valid (res_valid),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_seq   (out_seq),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Distinct per-result pattern: word w of result k is {k, 16'h5a00, w}.
  function automatic logic [255:0] mk_res(input int k);
    logic [255:0] d;
    for (int w = 0; w < 8; w++) begin
      d[255-32*w -: 32] = {8'(k), 16'h5a00, 8'(w)};
    end
    return d;
  endfunction

  task automatic do_reset();
    reset     = 1'b0;
    res_valid = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    res_data  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic pulse_res(input logic [255:0] d);
    res_valid = 1'b1;
    res_data  = d;
    @(negedge clock);
    res_valid = 1'b0;
  endtask

  // Receive one whole result; bp applies a 1,0,0 ready pattern, nobubble
  // requires out_valid on every sampled cycle.
  task automatic recv_result(input logic [255:0] d, input logic [7:0] seq,
                             input bit bp, input bit nobubble);
    int i = 0;
    int guard = 0;
    logic [31:0] w;
    while (i < 8 && guard < 200) begin
      if (bp) begin
        out_ready = (bp_phase % 3 == 0);
        bp_phase++;
      end else begin
        out_ready = 1'b1;
      end
      if (nobubble) check_val("nobubble", 64'(out_valid), 64'd1);
      if (out_valid) begin
        w = d[255-32*i -: 32];
        check_val("word", 64'(out_data), 64'(w));
        check_val("last", 64'(out_last), 64'(i == 7));
        check_val("seq", 64'(out_seq), 64'(seq));
        if (out_ready) i++;
      end
      guard++;
      @(negedge clock);
    end
    if (guard >= 200) check_val("recv_timeout", 64'(i), 64'd8);
  endtask

  initial begin
    do_reset();
    @(negedge clock);
    // Reset state
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_data", 64'(out_data), 64'd0);
    check_val("rst_last", 64'(out_last), 64'd0);
    check_val("rst_seq", 64'(out_seq), 64'd0);
    check_val("rst_level", 64'(level), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_drop", 64'(drop_cnt), 64'd0);

    // Single result: valid one cycle after capture
    out_ready = 1'b1;
    pulse_res(R1);
    check_val("lat_valid0", 64'(out_valid), 64'd0);
    check_val("lat_level1", 64'(level), 64'd1);
    @(negedge clock);
    check_val("lat_valid1", 64'(out_valid), 64'd1);
    recv_result(R1, 8'd0, 1'b0, 1'b1);
    check_val("single_done_valid", 64'(out_valid), 64'd0);
    check_val("single_done_level", 64'(level), 64'd0);

    // Two back-to-back results, 16 contiguous words
    do_reset();
    out_ready = 1'b1;
    pulse_res(R1);
    pulse_res(R2);
    recv_result(R1, 8'd0, 1'b0, 1'b1);
    recv_result(R2, 8'd1, 1'b0, 1'b1);
    check_val("b2b_level", 64'(level), 64'd0);
    check_val("b2b_valid", 64'(out_valid), 64'd0);

    // Backpressure: words held while stalled
    do_reset();
    pulse_res(R2);
    bp_phase = 0;
    recv_result(R2, 8'd0, 1'b1, 1'b0);
    pulse_res(R1);
    recv_result(R1, 8'd1, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clock);
    check_val("bp_level", 64'(level), 64'd0);

    // Overflow: six results while stalled
    do_reset();
    for (int k = 0; k < 6; k++) pulse_res(mk_res(k));
    check_val("ovf_level", 64'(level), 64'd4);
    check_val("ovf_flag", 64'(overflow), 64'd1);
    check_val("ovf_drop", 64'(drop_cnt), 64'd2);
    for (int k = 0; k < 4; k++) recv_result(mk_res(k), 8'(k), 1'b0, 1'b0);
    pulse_res(mk_res(6));
    recv_result(mk_res(6), 8'd6, 1'b0, 1'b0);
    check_val("ovf_sticky", 64'(overflow), 64'd1);
    check_val("ovf_drop_hold", 64'(drop_cnt), 64'd2);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    check_val("clr_flag", 64'(overflow), 64'd0);
    check_val("clr_drop", 64'(drop_cnt), 64'd0);

    // Full with a write coinciding with the final-word pop
    do_reset();
    for (int k = 0; k < 4; k++) pulse_res(mk_res(k));
    check_val("fullpop_level_pre", 64'(level), 64'd4);
    out_ready = 1'b1;
    repeat (7) @(negedge clock);
    check_val("fullpop_last", 64'(out_last), 64'd1);
    pulse_res(mk_res(9));
    check_val("fullpop_level", 64'(level), 64'd4);
    check_val("fullpop_ovf", 64'(overflow), 64'd0);
    check_val("fullpop_seq", 64'(out_seq), 64'd1);
    check_val("fullpop_valid", 64'(out_valid), 64'd1);
    for (int k = 1; k < 4; k++) recv_result(mk_res(k), 8'(k), 1'b0, 1'b1);
    recv_result(mk_res(9), 8'd4, 1'b0, 1'b1);

    // Reset in mid-transmission
    do_reset();
    out_ready = 1'b1;
    pulse_res(R1);
    @(negedge clock);
    repeat (3) @(negedge clock);
    check_val("midrst_word4", 64'(out_data), 64'h2d1b3c63);
    reset = 1'b0;
    @(negedge clock);
    check_val("midrst_valid", 64'(out_valid), 64'd0);
    check_val("midrst_level", 64'(level), 64'd0);
    reset = 1'b1;
    pulse_res(R2);
    recv_result(R2, 8'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
